// File: rtl/spi_frame_master.sv
// SPI master emitting a register-bus frame: header {addr,RnW} then N data words.
// Define SPI_FRAME_BYTESWAP_EN to send/receive words low byte first.
module spi_frame_master #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 15,
  parameter int CNT_W   = 5,
  parameter int HALF    = 2,
  parameter int SS_LEAD = 4,
  parameter int GAP     = 4,
  parameter int SS_LAG  = 8,
  parameter int SS_IDLE = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rnw,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              spi_ss,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int TW = 8;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HDR, S_GAP, S_DATA, S_LAG, S_RECOV
  } state_t;

  function automatic logic [DATA_W-1:0] swp(input logic [DATA_W-1:0] w);
`ifdef SPI_FRAME_BYTESWAP_EN
    swp = {w[7:0], w[DATA_W-1:8]};
`else
    swp = w;
`endif
  endfunction

  state_t            state;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     bcnt;
  logic [CNT_W-1:0]  wcnt;
  logic              rnw;
  logic [DATA_W-1:0] tx;
  logic [DATA_W-2:0] rx;
  logic [DATA_W-1:0] hdr_sw;
  logic [DATA_W-1:0] wr_sw;
  logic              last_word;

  assign hdr_sw = swp({cmd_addr, cmd_rnw});
  assign wr_sw  = swp(wr_data);
  assign last_word = (state == S_HDR) ? (wcnt == '0)
                                      : (wcnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      tmr       <= TW'(SS_IDLE - 1);
      bcnt      <= '0;
      wcnt      <= '0;
      rnw       <= 1'b0;
      tx        <= '0;
      rx        <= '0;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
      spi_ss    <= 1'b1;
      spi_sck   <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_ready) begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              busy      <= 1'b1;
              spi_ss    <= 1'b0;
              rnw       <= cmd_rnw;
              wcnt      <= cmd_count;
              tx        <= hdr_sw;
              tmr       <= TW'(SS_LEAD - 1);
              state     <= S_LEAD;
            end
          end else if (tmr == '0) begin
            cmd_ready <= 1'b1;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_LEAD: begin
          if (tmr == '0) begin
            spi_sck  <= 1'b0;
            spi_mosi <= tx[DATA_W-1];
            tx       <= {tx[DATA_W-2:0], 1'b0};
            bcnt     <= '0;
            tmr      <= TW'(HALF - 1);
            state    <= S_HDR;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_HDR, S_DATA: begin
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (!spi_sck) begin
            spi_sck <= 1'b1;
            tmr     <= TW'(HALF - 1);
            rx      <= {rx[DATA_W-3:0], spi_miso};
            if (state == S_DATA && rnw && bcnt == BW'(DATA_W - 1)) begin
              rd_valid <= 1'b1;
              rd_data  <= swp({rx, spi_miso});
            end
          end else if (bcnt != BW'(DATA_W - 1)) begin
            spi_sck  <= 1'b0;
            spi_mosi <= tx[DATA_W-1];
            tx       <= {tx[DATA_W-2:0], 1'b0};
            bcnt     <= bcnt + 1'b1;
            tmr      <= TW'(HALF - 1);
          end else begin
            if (state == S_DATA) wcnt <= wcnt - 1'b1;
            if (last_word) begin
              tmr   <= TW'(SS_LAG - 1);
              state <= S_LAG;
            end else begin
              tmr   <= TW'(GAP - 1);
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          // a write with no word available parks here with SCK high
          if (tmr != '0) begin
            tmr <= tmr - 1'b1;
          end else if (rnw || wr_valid) begin
            spi_sck  <= 1'b0;
            spi_mosi <= rnw ? 1'b0 : wr_sw[DATA_W-1];
            tx       <= rnw ? '0 : {wr_sw[DATA_W-2:0], 1'b0};
            wr_ready <= !rnw;
            bcnt     <= '0;
            tmr      <= TW'(HALF - 1);
            state    <= S_DATA;
          end
        end
        S_LAG: begin
          if (tmr == '0) begin
            spi_ss   <= 1'b1;
            spi_mosi <= 1'b0;
            tmr      <= TW'(SS_IDLE - 1);
            state    <= S_RECOV;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_RECOV: begin
          if (tmr == '0) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master with a bit-level SPI slave model.
// Expected wire framing follows SPI_FRAME_BYTESWAP_EN when defined.
module tb_spi_frame_master;

  localparam int DW      = 16;
  localparam int AW      = 15;
  localparam int CW      = 5;
  localparam int HALF    = 2;
  localparam int SS_LEAD = 4;
  localparam int GAP     = 4;
  localparam int SS_LAG  = 8;
  localparam int SS_IDLE = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_rnw = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          busy;
  logic          spi_ss;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_frame_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rnw(cmd_rnw), .cmd_count(cmd_count),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .spi_ss(spi_ss), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  typedef struct {
    int len;
    int nbits;
    int nwr;
  } frame_t;

  logic [DW-1:0] mosi_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] slave_q[$];
  frame_t        frame_q[$];

  int n_vec = 0;
  int n_err = 0;
  int bits_in_frame = 0;

  logic [DW-1:0] wd[32];
  int            st[32];
  logic [DW-1:0] rd_fix = '0;
  bit            use_fix = 1'b0;

  function automatic logic [DW-1:0] wire_of(input logic [DW-1:0] w);
`ifdef SPI_FRAME_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // slave + monitor: drives MISO on SCK fall, samples MOSI on SCK rise
  bit            prev_sck = 1'b1;
  bit            in_frame = 1'b0;
  bit            have_rise = 1'b0;
  int            len, falls, wrs, hi;
  logic [DW-1:0] sh, cur;
  frame_t        fe;

  always @(negedge clk) begin
    if (!resetn) begin
      in_frame      = 1'b0;
      have_rise     = 1'b0;
      bits_in_frame = 0;
      hi            = 0;
      prev_sck      = 1'b1;
    end else begin
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 0);
        else chk("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
      end
      if (!spi_ss) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          len = 0; falls = 0; wrs = 0; bits_in_frame = 0;
          if (have_rise) chk("ss_idle_gap", 32'(hi >= SS_IDLE), 1);
        end
        len++;
        if (wr_ready) wrs++;
        if (prev_sck && !spi_sck) begin
          falls++;
          if (bits_in_frame % DW == 0) begin
            if (slave_q.size() == 0) begin
              chk("slave_underrun", 32'(slave_q.size()), 1);
              cur = '0;
            end else begin
              cur = slave_q.pop_front();
            end
          end
          spi_miso <= cur[DW-1-(bits_in_frame % DW)];
        end
        if (!prev_sck && spi_sck) begin
          sh = {sh[DW-2:0], spi_mosi};
          bits_in_frame++;
          if (bits_in_frame % DW == 0) begin
            if (mosi_q.size() == 0) chk("mosi_unexpected", 32'(sh), 0);
            else chk("mosi_word", 32'(sh), 32'(mosi_q.pop_front()));
          end
        end
      end else if (in_frame) begin
        in_frame  = 1'b0;
        have_rise = 1'b1;
        hi        = 1;
        if (frame_q.size() == 0) begin
          chk("frame_unexpected", 32'(len), 0);
        end else begin
          fe = frame_q.pop_front();
          chk("ss_low_len", 32'(len), 32'(fe.len));
          chk("sck_bits", 32'(falls), 32'(fe.nbits));
          chk("wr_ready_cnt", 32'(wrs), 32'(fe.nwr));
        end
      end else begin
        hi++;
      end
      prev_sck = spi_sck;
    end
  end

  task automatic issue(input logic [AW-1:0] a, input bit r,
                       input int cnt, input bit wait_done);
    logic [DW-1:0] v;
    int            stall;
    int            k;
    frame_t        f;
    mosi_q.push_back(wire_of({a, r}));
    slave_q.push_back(DW'($urandom));
    stall = 0;
    for (int i = 0; i < cnt; i++) begin
      if (r) begin
        v = use_fix ? rd_fix : DW'($urandom);
        slave_q.push_back(wire_of(v));
        rd_q.push_back(v);
        mosi_q.push_back('0);
      end else begin
        mosi_q.push_back(wire_of(wd[i]));
        slave_q.push_back(DW'($urandom));
        if (i > 0) stall += st[i];
      end
    end
    f.len   = SS_LEAD + 2*HALF*DW*(1+cnt) + GAP*cnt + stall + SS_LAG;
    f.nbits = DW*(1+cnt);
    f.nwr   = r ? 0 : cnt;
    frame_q.push_back(f);
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (k == 400) chk("cmd_ready_timeout", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_rnw   = r;
    cmd_count = CW'(cnt);
    wr_valid  = !r && cnt > 0;
    wr_data   = wd[0];
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (!r) begin
      for (int i = 0; i < cnt; i++) begin
        for (k = 0; k < 3000; k++) begin
          @(negedge clk);
          if (wr_ready) break;
        end
        if (k == 3000) begin
          chk("wr_ready_timeout", 32'(wr_ready), 1);
          break;
        end
        if (i + 1 < cnt) begin
          if (st[i+1] == 0) begin
            wr_data = wd[i+1];
          end else begin
            wr_valid = 1'b0;
            repeat (2*HALF*DW + GAP - 1 + st[i+1]) @(posedge clk);
            #1;
            wr_valid = 1'b1;
            wr_data  = wd[i+1];
          end
        end else begin
          wr_valid = 1'b0;
        end
      end
    end
    if (wait_done) begin
      for (k = 0; k < 4000; k++) begin
        @(negedge clk);
        if (frame_q.size() == 0) break;
      end
      if (k == 4000) chk("frame_timeout", 32'(frame_q.size()), 0);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 32; i++) begin
      wd[i] = DW'($urandom);
      st[i] = 0;
    end
  endtask

  initial begin
    int k;
    int cnt;
    clear_tbl();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss", 32'(spi_ss), 1);
    chk("rst_sck", 32'(spi_sck), 1);
    chk("rst_mosi", 32'(spi_mosi), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("rst_idle_wait", 32'(k >= SS_IDLE && k <= 50), 1);

    // single write: header and data wire words come from the model
    clear_tbl();
    wd[0] = 16'h0001;
    issue(15'h7001, 1'b0, 1, 1'b1);

    // single read
    use_fix = 1'b1;
    rd_fix  = 16'hAA55;
    issue(15'h7001, 1'b1, 1, 1'b1);
    use_fix = 1'b0;

    // long burst write
    clear_tbl();
    issue(15'h6000, 1'b0, 18, 1'b1);

    // stalled write: word 2 withheld 20 clk past its slot
    clear_tbl();
    st[2] = 20;
    issue(15'h0155, 1'b0, 3, 1'b1);

    // back-to-back header-only frames
    issue(15'h1234, 1'b0, 0, 1'b1);
    issue(15'h0042, 1'b1, 0, 1'b1);

    // reset during data bit 7 of a read
    issue(15'h3333, 1'b1, 1, 1'b0);
    for (k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bits_in_frame == DW + 7) break;
    end
    if (k == 1000) chk("abort_point_timeout", 32'(bits_in_frame), DW + 7);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ss", 32'(spi_ss), 1);
    chk("abort_sck", 32'(spi_sck), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_valid", 32'(rd_valid), 0);
    mosi_q.delete();
    rd_q.delete();
    slave_q.delete();
    frame_q.delete();
    @(posedge clk);
    #1 resetn = 1'b1;

    issue(15'h0a0a, 1'b1, 2, 1'b1);
    clear_tbl();
    issue(15'h7fff, 1'b0, 2, 1'b1);

    for (int n = 0; n < 12; n++) begin
      clear_tbl();
      cnt = $urandom_range(0, 5);
      for (int i = 1; i < 32; i++)
        st[i] = ($urandom % 4 == 0) ? $urandom_range(1, 10) : 0;
      issue(AW'($urandom), 1'($urandom), cnt, 1'b1);
    end

    repeat (20) @(negedge clk);
    chk("mosi_q_left", 32'(mosi_q.size()), 0);
    chk("rd_q_left", 32'(rd_q.size()), 0);
    chk("frame_q_left", 32'(frame_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
